// File: rtl/banked_regfile.sv
// Banked register file: shared R0-R7, USR/FIQ R8-R12, per-mode R13-R14 and a PC.
// Reads are combinational (zero latency). Writes land on the next clk edge. There is no backpressure.
module banked_regfile #(
  parameter int            DW        = 32,
  parameter int            NRP       = 3,
  parameter logic [DW-1:0] PC_STEP   = DW'(4),
  parameter logic [DW-1:0] PC_RD_OFS = DW'(8),
  parameter logic [DW-1:0] RST_PC    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NRP-1:0]  r_addr,
  input  logic [3:0]        w_addr,
  input  logic [DW-1:0]     w_data,
  input  logic              write_reg,
  input  logic              write_pc,
  input  logic [DW-1:0]     pc_data,
  input  logic              pc_inc,
  input  logic [4:0]        M,
  output logic [DW*NRP-1:0] r_data,
  output logic [DW-1:0]     pc_out,
  output logic              mode_err
);

  localparam logic [4:0] M_USR = 5'b10000;
  localparam logic [4:0] M_FIQ = 5'b10001;
  localparam logic [4:0] M_IRQ = 5'b10010;
  localparam logic [4:0] M_SVC = 5'b10011;
  localparam logic [4:0] M_ABT = 5'b10111;
  localparam logic [4:0] M_UND = 5'b11011;
  localparam logic [4:0] M_SYS = 5'b11111;

  logic [DW-1:0] gpr_lo  [8];
  logic [DW-1:0] gpr_usr [5];
  logic [DW-1:0] gpr_fiq [5];
  logic [DW-1:0] gpr_bnk [6][2];
  logic [DW-1:0] pc_q;

  logic [2:0] bank;
  logic       is_fiq;

  // An illegal mode falls back to the USR bank (bank 0) for reads.
  always_comb begin
    bank     = 3'd0;
    is_fiq   = 1'b0;
    mode_err = 1'b0;
    case (M)
      M_USR, M_SYS: bank = 3'd0;
      M_FIQ: begin
        bank   = 3'd1;
        is_fiq = 1'b1;
      end
      M_IRQ:   bank = 3'd2;
      M_SVC:   bank = 3'd3;
      M_ABT:   bank = 3'd4;
      M_UND:   bank = 3'd5;
      default: mode_err = 1'b1;
    endcase
  end

  // R8-R12 map to slot a[2:0]; R13/R14 map to slot 0/1.
  function automatic logic [DW-1:0] rd_reg(input logic [3:0] a);
    logic [DW-1:0] v;
    if (a == 4'd15)
      v = pc_q + PC_RD_OFS;
    else if (!a[3])
      v = gpr_lo[a[2:0]];
    else if (a < 4'd13)
      v = is_fiq ? gpr_fiq[a[2:0]] : gpr_usr[a[2:0]];
    else
      v = gpr_bnk[bank][~a[0]];
    return v;
  endfunction

  always_comb begin
    r_data = '0;
    for (int k = 0; k < NRP; k++)
      r_data[DW*k +: DW] = rd_reg(r_addr[4*k +: 4]);
  end

  assign pc_out = pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) gpr_lo[i] <= '0;
      for (int i = 0; i < 5; i++) begin
        gpr_usr[i] <= '0;
        gpr_fiq[i] <= '0;
      end
      for (int b = 0; b < 6; b++) begin
        gpr_bnk[b][0] <= '0;
        gpr_bnk[b][1] <= '0;
      end
      pc_q <= RST_PC;
    end else begin
      if (write_reg && w_addr != 4'd15) begin
        if (!w_addr[3])
          gpr_lo[w_addr[2:0]] <= w_data;
        else if (!mode_err) begin
          if (w_addr < 4'd13) begin
            if (is_fiq) gpr_fiq[w_addr[2:0]] <= w_data;
            else        gpr_usr[w_addr[2:0]] <= w_data;
          end else
            gpr_bnk[bank][~w_addr[0]] <= w_data;
        end
      end

      if (write_pc)
        pc_q <= pc_data;
      else if (write_reg && w_addr == 4'd15)
        pc_q <= w_data;
      else if (pc_inc)
        pc_q <= pc_q + PC_STEP;
    end
  end

endmodule

// File: tb/tb_banked_regfile.sv
// Directed bench for banked_regfile with default parameters (DW=32, NRP=3).
module tb_banked_regfile;

  localparam logic [4:0] USR = 5'b10000;
  localparam logic [4:0] FIQ = 5'b10001;
  localparam logic [4:0] IRQ = 5'b10010;
  localparam logic [4:0] SVC = 5'b10011;
  localparam logic [4:0] ABT = 5'b10111;
  localparam logic [4:0] UND = 5'b11011;
  localparam logic [4:0] SYS = 5'b11111;
  localparam logic [4:0] BAD = 5'b01010;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] r_addr;
  logic [3:0]  w_addr;
  logic [31:0] w_data;
  logic        write_reg;
  logic        write_pc;
  logic [31:0] pc_data;
  logic        pc_inc;
  logic [4:0]  M;
  logic [95:0] r_data;
  logic [31:0] pc_out;
  logic        mode_err;

  int vecs = 0;
  int errs = 0;

  banked_regfile dut (
    .clk(clk), .rst(rst), .r_addr(r_addr), .w_addr(w_addr), .w_data(w_data),
    .write_reg(write_reg), .write_pc(write_pc), .pc_data(pc_data), .pc_inc(pc_inc),
    .M(M), .r_data(r_data), .pc_out(pc_out), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] port(input int k);
    return r_data[32*k +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] m, input logic [3:0] a, input logic [31:0] d);
    M = m; w_addr = a; w_data = d; write_reg = 1'b1;
    tick();
    write_reg = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; M = USR; r_addr = {4'd0, 4'd1, 4'd15};
    w_addr = '0; w_data = '0; write_reg = 0; write_pc = 0; pc_data = '0; pc_inc = 0;
    #3;
    vecs++; if (pc_out !== 32'd0)  begin errs++; $display("FAIL reset_pc got %h want 0", pc_out); end
    vecs++; if (port(0) !== 32'd8) begin errs++; $display("FAIL reset_r15 got %h want 8", port(0)); end
    vecs++; if (port(1) !== 32'd0) begin errs++; $display("FAIL reset_r1 got %h want 0", port(1)); end
    vecs++; if (mode_err !== 1'b0) begin errs++; $display("FAIL reset_mode_err got %b want 0", mode_err); end
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_pc_inc();
    pc_inc = 1'b1;
    repeat (3) tick();
    pc_inc = 1'b0;
    #1;
    vecs++; if (pc_out !== 32'd12)  begin errs++; $display("FAIL pc_inc3 got %h want c", pc_out); end
    vecs++; if (port(0) !== 32'd20) begin errs++; $display("FAIL pc_rd_ofs got %h want 14", port(0)); end
  endtask

  task automatic test_banking();
    wr(USR, 4'd13, 32'hAAAA);
    wr(IRQ, 4'd13, 32'hBBBB);
    r_addr = {4'd0, 4'd14, 4'd13};
    M = IRQ; #1;
    vecs++; if (port(0) !== 32'hBBBB) begin errs++; $display("FAIL irq_r13 got %h want bbbb", port(0)); end
    vecs++; if (port(1) !== 32'h0)    begin errs++; $display("FAIL irq_r14 got %h want 0", port(1)); end
    M = USR; #1;
    vecs++; if (port(0) !== 32'hAAAA) begin errs++; $display("FAIL usr_r13 got %h want aaaa", port(0)); end
    M = SYS; #1;
    vecs++; if (port(0) !== 32'hAAAA) begin errs++; $display("FAIL sys_r13 got %h want aaaa", port(0)); end
    M = SVC; #1;
    vecs++; if (port(0) !== 32'h0)    begin errs++; $display("FAIL svc_r13 got %h want 0", port(0)); end
  endtask

  task automatic test_fiq();
    wr(FIQ, 4'd9, 32'd5);
    wr(FIQ, 4'd3, 32'd7);
    wr(USR, 4'd12, 32'h55);
    r_addr = {4'd12, 4'd3, 4'd9};
    M = USR; #1;
    vecs++; if (port(0) !== 32'd0)   begin errs++; $display("FAIL usr_r9 got %h want 0", port(0)); end
    vecs++; if (port(1) !== 32'd7)   begin errs++; $display("FAIL usr_r3 got %h want 7", port(1)); end
    vecs++; if (port(2) !== 32'h55)  begin errs++; $display("FAIL usr_r12 got %h want 55", port(2)); end
    M = FIQ; #1;
    vecs++; if (port(0) !== 32'd5)   begin errs++; $display("FAIL fiq_r9 got %h want 5", port(0)); end
    vecs++; if (port(2) !== 32'd0)   begin errs++; $display("FAIL fiq_r12 got %h want 0", port(2)); end
    M = USR;
  endtask

  task automatic test_no_bypass();
    r_addr = {4'd0, 4'd0, 4'd4};
    M = USR; w_addr = 4'd4; w_data = 32'h77; write_reg = 1'b1;
    #1;
    vecs++; if (port(0) !== 32'd0)  begin errs++; $display("FAIL no_bypass got %h want 0", port(0)); end
    tick();
    write_reg = 1'b0;
    vecs++; if (port(0) !== 32'h77) begin errs++; $display("FAIL after_write got %h want 77", port(0)); end
  endtask

  task automatic test_pc_priority();
    write_pc = 1'b1; pc_data = 32'h100;
    write_reg = 1'b1; w_addr = 4'd15; w_data = 32'h200; pc_inc = 1'b1;
    tick();
    vecs++; if (pc_out !== 32'h100) begin errs++; $display("FAIL prio_wpc got %h want 100", pc_out); end
    write_pc = 1'b0;
    tick();
    vecs++; if (pc_out !== 32'h200) begin errs++; $display("FAIL prio_wreg15 got %h want 200", pc_out); end
    pc_inc = 1'b0;
    write_pc = 1'b1; pc_data = 32'hFFFF_FFFC;
    w_addr = 4'd2; w_data = 32'h22;
    tick();
    write_pc = 1'b0; write_reg = 1'b0;
    r_addr = {4'd0, 4'd15, 4'd2}; #1;
    vecs++; if (pc_out !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wpc_load got %h want fffffffc", pc_out); end
    vecs++; if (port(0) !== 32'h22) begin errs++; $display("FAIL wpc_plus_reg got %h want 22", port(0)); end
    vecs++; if (port(1) !== 32'h4)  begin errs++; $display("FAIL r15_wrap got %h want 4", port(1)); end
    pc_inc = 1'b1;
    tick();
    pc_inc = 1'b0;
    vecs++; if (pc_out !== 32'h0)   begin errs++; $display("FAIL pc_wrap got %h want 0", pc_out); end
  endtask

  task automatic test_mode_err();
    logic [4:0] legal [7];
    legal = '{USR, FIQ, IRQ, SVC, ABT, UND, SYS};
    for (int i = 0; i < 7; i++) begin
      M = legal[i]; #1;
      vecs++; if (mode_err !== 1'b0) begin errs++; $display("FAIL legal_mode %b got %b want 0", legal[i], mode_err); end
    end
    M = BAD; #1;
    vecs++; if (mode_err !== 1'b1) begin errs++; $display("FAIL bad_mode got %b want 1", mode_err); end
    wr(BAD, 4'd13, 32'd9);
    wr(BAD, 4'd1, 32'd9);
    r_addr = {4'd0, 4'd1, 4'd13}; #1;
    vecs++; if (port(0) !== 32'hAAAA) begin errs++; $display("FAIL bad_r13 got %h want aaaa", port(0)); end
    vecs++; if (port(1) !== 32'd9)    begin errs++; $display("FAIL bad_r1 got %h want 9", port(1)); end
    M = USR; #1;
    vecs++; if (port(0) !== 32'hAAAA) begin errs++; $display("FAIL usr_r13_kept got %h want aaaa", port(0)); end
  endtask

  task automatic test_multiport();
    wr(USR, 4'd6, 32'h66);
    wr(USR, 4'd10, 32'hA0);
    r_addr = {4'd15, 4'd10, 4'd6}; #1;
    vecs++; if (port(0) !== 32'h66) begin errs++; $display("FAIL mp_r6 got %h want 66", port(0)); end
    vecs++; if (port(1) !== 32'hA0) begin errs++; $display("FAIL mp_r10 got %h want a0", port(1)); end
    vecs++; if (port(2) !== 32'h8)  begin errs++; $display("FAIL mp_r15 got %h want 8", port(2)); end
  endtask

  task automatic test_async_reset();
    write_pc = 1'b1; pc_data = 32'h40;
    tick();
    write_pc = 1'b0;
    r_addr = {4'd0, 4'd5, 4'd1};
    M = USR; w_addr = 4'd5; w_data = 32'h99; write_reg = 1'b1; pc_inc = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    vecs++; if (pc_out !== 32'h0)   begin errs++; $display("FAIL arst_pc got %h want 0", pc_out); end
    vecs++; if (port(0) !== 32'h0)  begin errs++; $display("FAIL arst_r1 got %h want 0", port(0)); end
    tick();
    vecs++; if (port(1) !== 32'h0)  begin errs++; $display("FAIL arst_hold_r5 got %h want 0", port(1)); end
    write_reg = 1'b0; pc_inc = 1'b0;
    rst = 1'b1;
    tick();
    vecs++; if (port(1) !== 32'h0)  begin errs++; $display("FAIL arst_lost_r5 got %h want 0", port(1)); end
    vecs++; if (pc_out !== 32'h0)   begin errs++; $display("FAIL arst_after_pc got %h want 0", pc_out); end
  endtask

  initial begin
    test_reset();
    test_pc_inc();
    test_banking();
    test_fiq();
    test_no_bypass();
    test_pc_priority();
    test_mode_err();
    test_multiport();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
